// File: rtl/hazard_stall_unit.sv
// Stall/flush control beside ID: load-use, ID-branch operand and HI/LO busy hazards.
// Latency: outputs combinational from inputs and state; md_cnt and stall_cycles registered.
// Backpressure: a stall freezes PC and IF/ID and bubbles ID/EX; it overrides branch/jump flush.
module hazard_stall_unit #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        ID_rs,
  input  logic [4:0]        ID_rt,
  input  logic              ID_uses_rt,
  input  logic              ID_Branch,
  input  logic              ID_HiLo_read,
  input  logic              ID_MD_op,
  input  logic              Branch_taken_ID,
  input  logic              Jump_ID,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_RegWrite,
  input  logic [4:0]        ID_EX_Write_register,
  input  logic              EX_MEM_MemRead,
  input  logic [4:0]        EX_MEM_Write_register,
  input  logic              EX_MD_start,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Flush,
  output logic              MD_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0]  MD_LOAD  = CNT_W'(MD_LATENCY);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  logic [CNT_W-1:0] md_cnt;
  logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
  logic load_use, br_alu, br_load, md_haz, stall;

  // $0 is hardwired, so a zero destination never creates a dependency
  assign ex_rs_hit  = (ID_EX_Write_register != 5'd0)  && (ID_EX_Write_register == ID_rs);
  assign ex_rt_hit  = (ID_EX_Write_register != 5'd0)  && (ID_EX_Write_register == ID_rt);
  assign mem_rs_hit = (EX_MEM_Write_register != 5'd0) && (EX_MEM_Write_register == ID_rs);
  assign mem_rt_hit = (EX_MEM_Write_register != 5'd0) && (EX_MEM_Write_register == ID_rt);

  // MD_busy is masked during reset so the front end is never held while reset is high
  assign MD_busy  = (md_cnt != '0) && !reset;

  assign load_use = ID_EX_MemRead && (ex_rs_hit || (ex_rt_hit && ID_uses_rt));
  assign br_alu   = ID_Branch && ID_EX_RegWrite && (ex_rs_hit || ex_rt_hit);
  assign br_load  = ID_Branch && EX_MEM_MemRead && (mem_rs_hit || mem_rt_hit);
  assign md_haz   = (ID_HiLo_read || ID_MD_op) && MD_busy;
  assign stall    = !reset && (load_use || br_alu || br_load || md_haz);

  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    if (reset) begin
      IF_ID_Flush = 1'b0;
    end else if (stall) begin
      // branch outcome is meaningless while its operands are still in flight
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end else begin
      IF_ID_Flush = Branch_taken_ID || Jump_ID;
    end
  end

  // start wins over decrement, even on the last busy cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (EX_MD_start) begin
      md_cnt <= MD_LOAD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + PERF_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with a short mult/div latency and a 4-bit perf counter.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_rs, ID_rt;
  logic       ID_uses_rt, ID_Branch, ID_HiLo_read, ID_MD_op;
  logic       Branch_taken_ID, Jump_ID;
  logic       ID_EX_MemRead, ID_EX_RegWrite;
  logic [4:0] ID_EX_Write_register;
  logic       EX_MEM_MemRead;
  logic [4:0] EX_MEM_Write_register;
  logic       EX_MD_start;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_busy;
  logic [3:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  hazard_stall_unit #(.MD_LATENCY(4), .CNT_W(3), .PERF_W(4)) dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt), .ID_Branch(ID_Branch),
    .ID_HiLo_read(ID_HiLo_read), .ID_MD_op(ID_MD_op),
    .Branch_taken_ID(Branch_taken_ID), .Jump_ID(Jump_ID),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_Write_register(ID_EX_Write_register),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_Write_register(EX_MEM_Write_register),
    .EX_MD_start(EX_MD_start),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .MD_busy(MD_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // control bundle order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}
  localparam logic [3:0] RUN   = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] FLUSH = 4'b1110;

  task automatic set_idle();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b0; ID_Branch = 1'b0;
    ID_HiLo_read = 1'b0; ID_MD_op = 1'b0; Branch_taken_ID = 1'b0; Jump_ID = 1'b0;
    ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_Write_register = 5'd0;
    EX_MEM_MemRead = 1'b0; EX_MEM_Write_register = 5'd0; EX_MD_start = 1'b0;
  endtask

  // inputs change 1ns after the rising edge; outputs are sampled 1ns later
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle();
    next_cycle();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    ID_rs = 5'd8; ID_rt = 5'd8; ID_uses_rt = 1'b1; ID_Branch = 1'b1; ID_HiLo_read = 1'b1;
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_Write_register = 5'd8;
    EX_MEM_MemRead = 1'b1; EX_MEM_Write_register = 5'd8; Branch_taken_ID = 1'b1;
    next_cycle();
    checks++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== RUN) begin errors++;
      $display("FAIL reset_ctrl got %b exp %b", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, RUN); end
    checks++; if (MD_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy got %b exp 0", MD_busy); end
    checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cycles); end
    set_idle();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_load_use();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_Write_register = 5'd8; ID_rs = 5'd8;
    #1;
    checks++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== STALL) begin errors++;
      $display("FAIL load_use_rs got %b exp %b", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, STALL); end
    next_cycle();
    ID_EX_Write_register = 5'd0; ID_rs = 5'd0;
    #1;
    checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL load_use_cnt got %0d exp 1", stall_cycles); end
    checks++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== RUN) begin errors++;
      $display("FAIL load_use_r0 got %b exp %b", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, RUN); end
    ID_EX_Write_register = 5'd8; ID_rt = 5'd8; ID_uses_rt = 1'b0;
    #1;
    checks++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== RUN) begin errors++;
      $display("FAIL load_use_rt_unused got %b exp %b", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, RUN); end
    ID_uses_rt = 1'b1;
    #1;
    checks++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== STALL) begin errors++;
      $display("FAIL load_use_rt got %b exp %b", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, STALL); end
    next_cycle();
    set_idle();
    #1;
    checks++; if (stall_cycles !== 4'd2) begin errors++; $display("FAIL load_use_cnt2 got %0d exp 2", stall_cycles); end
  endtask

  task automatic test_branch_alu();
    do_reset();
    ID_Branch = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_Write_register = 5'd9; ID_rt = 5'd9;
    Branch_taken_ID = 1'b1;
    #1;
    checks++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== STALL) begin errors++;
      $display("FAIL br_alu_stall got %b exp %b", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, STALL); end
    next_cycle();
    ID_EX_Write_register = 5'd10;
    #1;
    checks++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== FLUSH) begin errors++;
      $display("FAIL br_alu_taken got %b exp %b", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, FLUSH); end
    set_idle();
    #1;
  endtask

  task automatic test_branch_load();
    do_reset();
    ID_Branch = 1'b1; EX_MEM_MemRead = 1'b1; EX_MEM_Write_register = 5'd4; ID_rs = 5'd4;
    #1;
    checks++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== STALL) begin errors++;
      $display("FAIL br_load_stall got %b exp %b", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, STALL); end
    ID_Branch = 1'b0;
    #1;
    checks++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== RUN) begin errors++;
      $display("FAIL br_load_nobranch got %b exp %b", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, RUN); end
    Jump_ID = 1'b1;
    #1;
    checks++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== FLUSH) begin errors++;
      $display("FAIL jump_flush got %b exp %b", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, FLUSH); end
    set_idle();
    #1;
  endtask

  task automatic test_mult_div();
    do_reset();
    EX_MD_start = 1'b1; ID_HiLo_read = 1'b1;
    #1;
    checks++; if (MD_busy !== 1'b0 || PC_Write !== 1'b1) begin errors++;
      $display("FAIL md_c0 got busy=%b pc=%b exp busy=0 pc=1", MD_busy, PC_Write); end
    next_cycle();
    EX_MD_start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      checks++; if (MD_busy !== (c <= 4) || PC_Write !== (c > 4)) begin errors++;
        $display("FAIL md_cycle%0d got busy=%b pc=%b exp busy=%b pc=%b", c, MD_busy, PC_Write, c <= 4, c > 4); end
      next_cycle();
    end
    checks++; if (stall_cycles !== 4'd4) begin errors++; $display("FAIL md_cnt got %0d exp 4", stall_cycles); end
    // restart on the last busy cycle must reload the full latency
    ID_HiLo_read = 1'b0; ID_MD_op = 1'b1;
    EX_MD_start = 1'b1;
    next_cycle();
    EX_MD_start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      EX_MD_start = (c == 4);
      #1;
      checks++; if (MD_busy !== (c <= 8)) begin errors++;
        $display("FAIL md_restart%0d got %b exp %b", c, MD_busy, c <= 8); end
      next_cycle();
    end
    set_idle();
    #1;
  endtask

  task automatic test_reset_mid_divide();
    do_reset();
    EX_MD_start = 1'b1; ID_HiLo_read = 1'b1;
    next_cycle();
    EX_MD_start = 1'b0;
    next_cycle();
    reset = 1'b1;
    #1;
    checks++; if (MD_busy !== 1'b0 || PC_Write !== 1'b1) begin errors++;
      $display("FAIL rst_mid_during got busy=%b pc=%b exp busy=0 pc=1", MD_busy, PC_Write); end
    next_cycle();
    reset = 1'b0;
    #1;
    checks++; if (MD_busy !== 1'b0 || stall_cycles !== 4'd0) begin errors++;
      $display("FAIL rst_mid_after got busy=%b cnt=%0d exp busy=0 cnt=0", MD_busy, stall_cycles); end
    set_idle();
    #1;
  endtask

  task automatic test_saturation();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_Write_register = 5'd8; ID_rs = 5'd8;
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++; if (stall_cycles !== 4'((c > 15) ? 15 : c)) begin errors++;
        $display("FAIL sat_cycle%0d got %0d exp %0d", c, stall_cycles, (c > 15) ? 15 : c); end
      next_cycle();
    end
    set_idle();
    #1;
    checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_final got %0d exp 15", stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_alu();
    test_branch_load();
    test_mult_div();
    test_reset_mid_divide();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
